// File: rtl/regfile_rr_arbiter.sv
// Shared DEPTH x WIDTH register file with a round-robin arbiter among NUM_REQ requesters.
// Single-beat read/write transfers, 1-cycle read latency, optional lock for back-to-back grants.
module regfile_rr_arbiter #(
   parameter int unsigned      NUM_REQ   = 4,
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      DEPTH     = 16,
   parameter int unsigned      ADDR_W    = $clog2(DEPTH),
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ-1:0]          req_we,
   input  logic [NUM_REQ-1:0]          req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [WIDTH-1:0]            rsp_rdata,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

   localparam int unsigned     ID_W    = $clog2(NUM_REQ);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   logic [WIDTH-1:0]   mem [DEPTH];

   logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
   logic               lock_active, lock_active_nxt;
   logic [ID_W-1:0]    lock_owner, lock_owner_nxt;
   logic [NUM_REQ-1:0] rsp_valid_nxt;
   logic [WIDTH-1:0]   rsp_rdata_nxt;

   logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
   logic [WIDTH-1:0]   wdata_arr [NUM_REQ];

   logic               gnt_any;
   logic [ID_W-1:0]    gnt_idx;
   logic               xfer;
   logic               sel_we;
   logic               sel_lock;
   logic [ADDR_W-1:0]  sel_addr;
   logic [WIDTH-1:0]   sel_wdata;
   logic               in_range;
   logic [ID_W-1:0]    next_ptr;

   // Unpack the flat per-requester address and write-data buses
   for (genvar gi = 0; gi < int'(NUM_REQ); gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
   end

   // Grant selection: a held lock wins, otherwise first valid at or after rr_ptr
   always_comb begin
      int idx;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      if (lock_active && req_valid[lock_owner]) begin
         gnt_any = 1'b1;
         gnt_idx = lock_owner;
      end else begin
         // Descending scan so the closest requester to rr_ptr is assigned last
         for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= int'(NUM_REQ)) begin
               idx = idx - int'(NUM_REQ);
            end
            if (req_valid[ID_W'(idx)]) begin
               gnt_any = 1'b1;
               gnt_idx = ID_W'(idx);
            end
         end
      end
   end

   assign xfer      = gnt_any && !rst;
   assign req_ready = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign grant_id  = xfer ? gnt_idx : '0;

   assign sel_we    = req_we[gnt_idx];
   assign sel_lock  = req_lock[gnt_idx];
   assign sel_addr  = addr_arr[gnt_idx];
   assign sel_wdata = wdata_arr[gnt_idx];
   assign in_range  = {1'b0, sel_addr} < DEPTH_L;
   assign next_ptr  = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;

   // Next-state for arbitration pointer, lock and read response
   always_comb begin
      rr_ptr_nxt      = rr_ptr;
      lock_active_nxt = lock_active;
      lock_owner_nxt  = lock_owner;
      rsp_valid_nxt   = '0;
      rsp_rdata_nxt   = rsp_rdata;
      if (xfer) begin
         rr_ptr_nxt      = next_ptr;
         lock_active_nxt = sel_lock;
         if (sel_lock) begin
            lock_owner_nxt = gnt_idx;
         end
         if (!sel_we) begin
            rsp_valid_nxt = req_ready;
            rsp_rdata_nxt = in_range ? mem[sel_addr] : '0;
         end
      end else if (lock_active && !req_valid[lock_owner]) begin
         lock_active_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr      <= '0;
         lock_active <= 1'b0;
         lock_owner  <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
      end else begin
         rr_ptr      <= rr_ptr_nxt;
         lock_active <= lock_active_nxt;
         lock_owner  <= lock_owner_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
      end
   end

   // Storage; out-of-range writes are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= RESET_VAL;
         end
      end else if (xfer && sel_we && in_range) begin
         mem[sel_addr] <= sel_wdata;
      end
   end

endmodule

// File: tb/tb_regfile_rr_arbiter.sv
// Self-checking bench for regfile_rr_arbiter against a behavioural arbitration/storage model.
module tb_regfile_rr_arbiter;

   localparam int          N  = 4;
   localparam int          D  = 12;
   localparam logic [31:0] RV = 32'hA5A5_0000;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid, req_ready, req_we, req_lock, rsp_valid;
   logic [15:0]  req_addr;
   logic [127:0] req_wdata;
   logic [31:0]  rsp_rdata;
   logic [1:0]   grant_id;

   logic [3:0]   a_addr  [N];
   logic [31:0]  a_wdata [N];

   assign req_addr  = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
   assign req_wdata = {a_wdata[3], a_wdata[2], a_wdata[1], a_wdata[0]};

   always #5 clk = ~clk;

   regfile_rr_arbiter #(
      .NUM_REQ  (N),
      .WIDTH    (32),
      .DEPTH    (D),
      .RESET_VAL(RV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_lock (req_lock),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .grant_id (grant_id)
   );

   // Reference model state
   logic [31:0] m_mem [D];
   int          m_ptr;
   bit          m_lock;
   int          m_owner;
   int          m_gnt;
   logic [3:0]  m_rsp_valid;
   logic [31:0] m_rsp_rdata;
   logic [3:0]  exp_ready;
   logic [1:0]  exp_gid;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic int model_grant();
      if (rst) return -1;
      if (m_lock && req_valid[m_owner]) return m_owner;
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic set_idle();
      req_valid = '0;
      req_we    = '0;
      req_lock  = '0;
      for (int i = 0; i < N; i++) begin
         a_addr[i]  = '0;
         a_wdata[i] = '0;
      end
   endtask

   task automatic set_req(input int i, input bit we, input bit lk, input int addr, input logic [31:0] wd);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_lock[i]  = lk;
      a_addr[i]    = 4'(addr);
      a_wdata[i]   = wd;
   endtask

   // Let inputs settle, then compute the grant the rules require
   task automatic predict();
      #1;
      m_gnt     = model_grant();
      exp_ready = (m_gnt >= 0) ? 4'(1 << m_gnt) : 4'd0;
      exp_gid   = (m_gnt >= 0) ? 2'(m_gnt) : 2'd0;
   endtask

   // Clock one edge and apply the transfer (or reset) to the model
   task automatic advance();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < D; i++) m_mem[i] = RV;
         m_ptr = 0; m_lock = 0; m_owner = 0;
         m_rsp_valid = '0; m_rsp_rdata = '0;
      end else if (m_gnt >= 0) begin
         m_ptr  = (m_gnt + 1) % N;
         m_lock = req_lock[m_gnt];
         if (req_lock[m_gnt]) m_owner = m_gnt;
         if (req_we[m_gnt]) begin
            if (int'(a_addr[m_gnt]) < D) m_mem[a_addr[m_gnt]] = a_wdata[m_gnt];
            m_rsp_valid = '0;
         end else begin
            m_rsp_valid = 4'(1 << m_gnt);
            m_rsp_rdata = (int'(a_addr[m_gnt]) < D) ? m_mem[a_addr[m_gnt]] : 32'd0;
         end
      end else begin
         m_rsp_valid = '0;
         m_lock      = 1'b0;
      end
      #1;
   endtask

   task automatic pulse_reset();
      set_idle();
      rst = 1'b1;
      predict();
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1'b1;
      req_valid = 4'hF;
      predict();
      n_checks++;
      if (req_ready !== 4'd0 || grant_id !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_ready: ready=%b gid=%0d expected ready=0000 gid=0", req_ready, grant_id);
      end
      advance();
      advance();
      n_checks++;
      if (rsp_valid !== 4'd0 || rsp_rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_rsp: rsp_valid=%b rdata=%h expected 0000/0", rsp_valid, rsp_rdata);
      end
      rst = 1'b0;
      for (int a = 0; a < D; a++) begin
         set_idle();
         set_req(a % N, 1'b0, 1'b0, a, $urandom);
         predict();
         n_checks++;
         if (req_ready !== exp_ready || grant_id !== exp_gid) begin
            n_fail++;
            $display("FAIL reset_read_grant a=%0d: ready=%b gid=%0d expected %b/%0d", a, req_ready, grant_id, exp_ready, exp_gid);
         end
         advance();
         n_checks++;
         if (rsp_valid !== 4'(1 << (a % N)) || rsp_rdata !== RV) begin
            n_fail++;
            $display("FAIL reset_read_data a=%0d: rsp_valid=%b rdata=%h expected %b/%h", a, rsp_valid, rsp_rdata, 4'(1 << (a % N)), RV);
         end
      end
   endtask

   task automatic test_round_robin();
      int waits [N];
      pulse_reset();
      for (int i = 0; i < N; i++) waits[i] = 0;
      for (int c = 0; c < 16; c++) begin
         set_idle();
         for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, $urandom_range(0, D - 1), '0);
         predict();
         n_checks++;
         if (grant_id !== 2'(c % N) || req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL rr_grant c=%0d: gid=%0d ready=%b expected %0d/%b", c, grant_id, req_ready, c % N, exp_ready);
         end
         for (int i = 0; i < N; i++) waits[i] = req_ready[i] ? 0 : waits[i] + 1;
         for (int i = 0; i < N; i++) begin
            n_checks++;
            if (waits[i] > 3) begin
               n_fail++;
               $display("FAIL rr_wait req=%0d: waited %0d cycles expected <= 3", i, waits[i]);
            end
         end
         advance();
         n_checks++;
         if (rsp_valid !== m_rsp_valid || rsp_rdata !== m_rsp_rdata) begin
            n_fail++;
            $display("FAIL rr_rsp c=%0d: %b/%h expected %b/%h", c, rsp_valid, rsp_rdata, m_rsp_valid, m_rsp_rdata);
         end
      end
   endtask

   task automatic test_write_read();
      set_idle();
      set_req(2, 1'b1, 1'b0, 5, 32'hDEAD_BEEF);
      predict();
      n_checks++;
      if (req_ready !== 4'b0100 || grant_id !== 2'd2) begin
         n_fail++;
         $display("FAIL wr_grant: ready=%b gid=%0d expected 0100/2", req_ready, grant_id);
      end
      advance();
      set_idle();
      set_req(0, 1'b0, 1'b0, 5, '0);
      predict();
      n_checks++;
      if (rsp_valid !== 4'd0 || req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL wr_no_rsp: rsp_valid=%b ready=%b expected 0000/0001", rsp_valid, req_ready);
      end
      advance();
      n_checks++;
      if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL wr_rd_data: %b/%h expected 0001/deadbeef", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_lock();
      int exp_seq [6] = '{1, 1, 1, 1, 3, 0};
      int n1 = 0;
      pulse_reset();
      set_idle();
      set_req(0, 1'b0, 1'b0, 0, '0);
      predict();
      advance();
      for (int c = 0; c < 6; c++) begin
         set_idle();
         set_req(0, 1'b0, 1'b0, 1, '0);
         set_req(3, 1'b0, 1'b0, 2, '0);
         if (n1 < 4) set_req(1, 1'b0, (n1 < 3), 3, '0);
         predict();
         n_checks++;
         if (grant_id !== 2'(exp_seq[c]) || req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL lock_seq c=%0d: gid=%0d ready=%b expected %0d/%b", c, grant_id, req_ready, exp_seq[c], exp_ready);
         end
         if (req_ready[1]) n1++;
         advance();
         n_checks++;
         if (rsp_valid !== m_rsp_valid || rsp_rdata !== m_rsp_rdata) begin
            n_fail++;
            $display("FAIL lock_rsp c=%0d: %b/%h expected %b/%h", c, rsp_valid, rsp_rdata, m_rsp_valid, m_rsp_rdata);
         end
      end
      // Owner drops valid: lock releases and round-robin applies that same cycle
      set_idle();
      set_req(1, 1'b0, 1'b1, 4, '0);
      predict();
      advance();
      set_idle();
      set_req(0, 1'b0, 1'b0, 4, '0);
      set_req(3, 1'b0, 1'b0, 4, '0);
      predict();
      n_checks++;
      if (grant_id !== 2'd3 || req_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL lock_drop: gid=%0d ready=%b expected 3/%b", grant_id, req_ready, exp_ready);
      end
      advance();
      set_idle();
      set_req(0, 1'b0, 1'b0, 4, '0);
      set_req(1, 1'b0, 1'b0, 4, '0);
      predict();
      n_checks++;
      if (grant_id !== 2'd0 || req_ready !== exp_ready) begin
         n_fail++;
         $display("FAIL lock_released: gid=%0d ready=%b expected 0/%b", grant_id, req_ready, exp_ready);
      end
      advance();
   endtask

   task automatic test_out_of_range();
      set_idle();
      set_req(1, 1'b1, 1'b0, 13, 32'h1234);
      predict();
      advance();
      set_idle();
      set_req(3, 1'b0, 1'b0, 13, '0);
      predict();
      advance();
      n_checks++;
      if (rsp_valid !== 4'b1000 || rsp_rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL oor_read: %b/%h expected 1000/0", rsp_valid, rsp_rdata);
      end
      for (int a = 0; a < D; a++) begin
         set_idle();
         set_req(a % N, 1'b0, 1'b0, a, '0);
         predict();
         advance();
         n_checks++;
         if (rsp_valid !== m_rsp_valid || rsp_rdata !== m_rsp_rdata) begin
            n_fail++;
            $display("FAIL oor_entry a=%0d: %b/%h expected %b/%h", a, rsp_valid, rsp_rdata, m_rsp_valid, m_rsp_rdata);
         end
      end
   endtask

   task automatic test_reset_mid();
      set_idle();
      set_req(0, 1'b1, 1'b0, 7, 32'h0BAD_CAFE);
      predict();
      advance();
      set_idle();
      set_req(2, 1'b0, 1'b0, 7, '0);
      predict();
      advance();
      set_idle();
      rst = 1'b1;
      set_req(1, 1'b1, 1'b0, 3, 32'h5555_AAAA);
      predict();
      n_checks++;
      if (req_ready !== 4'd0 || rsp_valid !== 4'b0100 || rsp_rdata !== 32'h0BAD_CAFE) begin
         n_fail++;
         $display("FAIL mid_rst_inflight: ready=%b rsp=%b/%h expected 0000 0100/0badcafe", req_ready, rsp_valid, rsp_rdata);
      end
      advance();
      rst = 1'b0;
      set_idle();
      n_checks++;
      if (rsp_valid !== 4'd0) begin
         n_fail++;
         $display("FAIL mid_rst_squash: rsp_valid=%b expected 0000", rsp_valid);
      end
      set_req(1, 1'b0, 1'b0, 7, '0);
      set_req(3, 1'b0, 1'b0, 3, '0);
      predict();
      n_checks++;
      if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL mid_rst_first_grant: gid=%0d ready=%b expected 1/0010", grant_id, req_ready);
      end
      advance();
      n_checks++;
      if (rsp_valid !== 4'b0010 || rsp_rdata !== RV) begin
         n_fail++;
         $display("FAIL mid_rst_entry7: %b/%h expected 0010/%h", rsp_valid, rsp_rdata, RV);
      end
      req_valid[1] = 1'b0;
      predict();
      advance();
      n_checks++;
      if (rsp_valid !== 4'b1000 || rsp_rdata !== RV) begin
         n_fail++;
         $display("FAIL mid_rst_entry3: %b/%h expected 1000/%h", rsp_valid, rsp_rdata, RV);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         set_idle();
         rst = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 2) != 0) begin
               set_req(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 15), $urandom);
            end
         end
         predict();
         n_checks++;
         if (req_ready !== exp_ready || grant_id !== exp_gid) begin
            n_fail++;
            $display("FAIL rand_grant c=%0d: ready=%b gid=%0d expected %b/%0d", c, req_ready, grant_id, exp_ready, exp_gid);
         end
         advance();
         n_checks++;
         if (rsp_valid !== m_rsp_valid || rsp_rdata !== m_rsp_rdata) begin
            n_fail++;
            $display("FAIL rand_rsp c=%0d: %b/%h expected %b/%h", c, rsp_valid, rsp_rdata, m_rsp_valid, m_rsp_rdata);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      m_ptr = 0; m_lock = 0; m_owner = 0; m_gnt = -1;
      m_rsp_valid = '0; m_rsp_rdata = '0;
      for (int i = 0; i < D; i++) m_mem[i] = RV;
      @(posedge clk);
      #1;
      test_reset();
      test_round_robin();
      test_write_read();
      test_lock();
      test_out_of_range();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regfile_rr_arbiter.md
Name: regfile_rr_arbiter

Overview:
- Shares one synchronous register file (DEPTH x WIDTH) among NUM_REQ requesters.
- Each requester issues single-beat read or write transactions over a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle and supports an optional lock for back-to-back ownership.
- Sits between independent control agents (CSR masters, sequencers) and shared configuration/state storage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, data width of each register entry.
- DEPTH, 16, number of entries (need not be a power of 2).
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).
- RESET_VAL, '0, value loaded into every entry on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester transaction valid.
- req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
- req_we  input  NUM_REQ  1 = write, 0 = read.
- req_lock  input  NUM_REQ  hold grant for the next cycle after this transfer.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH].
- rsp_valid  output  NUM_REQ  one-hot read-response strobe.
- rsp_rdata  output  WIDTH  read data, broadcast; qualify with rsp_valid.
- grant_id  output  $clog2(NUM_REQ)  index of the current grant; 0 when idle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all entries = RESET_VAL; rr_ptr = 0; lock_active = 0; lock_owner = 0; rsp_valid = 0; rsp_rdata = 0. While rst = 1, req_ready = 0 and no transfer occurs.
- Grant selection (combinational from registered state and req_valid):
  - If lock_active and req_valid[lock_owner] = 1: grant lock_owner.
  - Otherwise: grant the first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[i] = 1 only for the granted i. Ready never asserts without valid.
- Transfer: occurs when req_valid[i] and req_ready[i] are both 1. At most one transfer per cycle. Throughput is 1 transaction per cycle.
- Write:
  - entry[addr] <= wdata at the transfer edge.
  - A read in the next cycle returns the new value.
  - Writes with addr >= DEPTH are dropped silently.
- Read:
  - rsp_valid[i] = 1 and rsp_rdata = entry[addr] in the cycle after the transfer. Latency is exactly 1 cycle; no backpressure on responses.
  - addr >= DEPTH returns 0 and still asserts rsp_valid.
  - When no read completes, rsp_valid = 0 and rsp_rdata holds its last value.
- Pointer update:
  - On a transfer by i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no transfer, rr_ptr is unchanged.
  - A locked transfer also updates rr_ptr, so fairness resumes after the lock releases.
- Lock:
  - On a transfer by i with req_lock[i] = 1: lock_active <= 1, lock_owner <= i.
  - On a transfer with req_lock = 0: lock_active <= 0.
  - If lock_active and the owner drops req_valid: lock_active <= 0 at that edge, and normal round-robin applies in that same cycle.
- grant_id: the granted index when any req_ready is high, else 0.
- Reset mid-operation: an in-flight read response is squashed (rsp_valid = 0 next cycle). An accepted write on the reset edge is discarded, and the entry takes RESET_VAL.

Test Plan:
- Reset then read all entries with RESET_VAL = 32'hA5A5_0000 -> every rsp_rdata = 32'hA5A5_0000, rsp_valid one cycle after each grant.
- All 4 requesters hold valid reads continuously from reset -> grants 0,1,2,3,0,1,... one per cycle. No requester waits more than 3 cycles.
- Req 2 writes addr 5 = 32'hDEAD_BEEF in cycle N, req 0 reads addr 5 in cycle N+1 -> rsp_valid[0] = 1 in N+2 with rsp_rdata = 32'hDEAD_BEEF.
- Req 1 holds req_lock for 3 transfers while reqs 0 and 3 are valid -> grants 1,1,1,1; then the 4th transfer has lock = 0 -> next grant is 3 (rr_ptr = 2), then 0.
- DEPTH = 12: write addr 13 = 32'h1234, then read addr 13 -> rsp_rdata = 0; all 12 valid entries unchanged.
- Assert rst in the cycle after a read grant -> rsp_valid stays 0, rr_ptr = 0, and the first post-reset grant goes to the lowest valid index.
